// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 phase sequencer: FSM states, phase owner codes
// and default S memory geometry.
package arc4_pkg;

  localparam int ARC4_ADDR_W = 8;
  localparam int ARC4_DATA_W = 8;

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_INIT = 2'd1;
  localparam logic [1:0] PH_KSA  = 2'd2;
  localparam logic [1:0] PH_PRGA = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_GO,
    ST_INIT_RUN,
    ST_KSA_GO,
    ST_KSA_RUN,
    ST_PRGA_GO,
    ST_PRGA_RUN,
    ST_ERR
  } state_t;

  // Owner of the S port for a given state; the mux is granted on GO entry.
  function automatic logic [1:0] phase_of(input state_t st);
    logic [1:0] ph;
    ph = PH_NONE;
    case (st)
      ST_INIT_GO, ST_INIT_RUN: ph = PH_INIT;
      ST_KSA_GO,  ST_KSA_RUN:  ph = PH_KSA;
      ST_PRGA_GO, ST_PRGA_RUN: ph = PH_PRGA;
      default:                 ph = PH_NONE;
    endcase
    return ph;
  endfunction

  function automatic logic is_active(input state_t st);
    return (st != ST_IDLE) && (st != ST_ERR);
  endfunction

endpackage

// File: rtl/arc4_sched_if.sv
// Sequencer-facing bundle: upstream start/status, per-engine rdy/en handshake
// and memory port, and the single physical S port.
interface arc4_sched_if
  import arc4_pkg::*;
#(
  parameter int ADDR_W = ARC4_ADDR_W,
  parameter int DATA_W = ARC4_DATA_W
);

  logic              en;
  logic              rdy;
  logic              err;
  logic [1:0]        phase;

  logic              init_en;
  logic              ksa_en;
  logic              prga_en;
  logic              init_rdy;
  logic              ksa_rdy;
  logic              prga_rdy;

  logic [ADDR_W-1:0] init_addr;
  logic [ADDR_W-1:0] ksa_addr;
  logic [ADDR_W-1:0] prga_addr;
  logic [DATA_W-1:0] init_wrdata;
  logic [DATA_W-1:0] ksa_wrdata;
  logic [DATA_W-1:0] prga_wrdata;
  logic              init_wren;
  logic              ksa_wren;
  logic              prga_wren;

  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wrdata;
  logic              s_wren;

  modport master (
    input  en,
    input  init_rdy, ksa_rdy, prga_rdy,
    input  init_addr, ksa_addr, prga_addr,
    input  init_wrdata, ksa_wrdata, prga_wrdata,
    input  init_wren, ksa_wren, prga_wren,
    output rdy, err, phase,
    output init_en, ksa_en, prga_en,
    output s_addr, s_wrdata, s_wren
  );

  modport slave (
    output en,
    output init_rdy, ksa_rdy, prga_rdy,
    output init_addr, ksa_addr, prga_addr,
    output init_wrdata, ksa_wrdata, prga_wrdata,
    output init_wren, ksa_wren, prga_wren,
    input  rdy, err, phase,
    input  init_en, ksa_en, prga_en,
    input  s_addr, s_wrdata, s_wren
  );

endinterface

// File: rtl/arc4_smem_mux.sv
// Combinational 3:1 S port mux keyed by the registered phase owner.
// Unowned phase parks the port at zero with write disabled.
module arc4_smem_mux
  import arc4_pkg::*;
#(
  parameter int ADDR_W = ARC4_ADDR_W,
  parameter int DATA_W = ARC4_DATA_W
) (
  input  logic [1:0]        phase,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic              ksa_wren,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren
);

  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (phase)
      PH_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      PH_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      PH_PRGA: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 phase sequencer: runs init -> KSA -> PRGA on the shared S port, each
// started by a one-cycle en once the engine is rdy; a per-phase watchdog latches err.
module arc4_sched
  import arc4_pkg::*;
#(
  parameter int ADDR_W  = ARC4_ADDR_W,
  parameter int DATA_W  = ARC4_DATA_W,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  arc4_sched_if.master  bus
);

  localparam int              WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            seen_low_q, seen_low_d;
  logic            rdy_q, rdy_d;
  logic            err_q, err_d;
  logic [1:0]      phase_q, phase_d;
  logic            init_en_q, init_en_d;
  logic            ksa_en_q, ksa_en_d;
  logic            prga_en_q, prga_en_d;
  logic            cur_rdy;

  always_comb begin
    cur_rdy = 1'b0;
    case (phase_q)
      PH_INIT: cur_rdy = bus.init_rdy;
      PH_KSA:  cur_rdy = bus.ksa_rdy;
      PH_PRGA: cur_rdy = bus.prga_rdy;
      default: cur_rdy = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    seen_low_d = seen_low_q;
    init_en_d  = 1'b0;
    ksa_en_d   = 1'b0;
    prga_en_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.en) state_d = ST_INIT_GO;
      end
      ST_INIT_GO: begin
        if (cur_rdy) begin
          state_d    = ST_INIT_RUN;
          init_en_d  = 1'b1;
          seen_low_d = 1'b0;
        end
      end
      ST_KSA_GO: begin
        if (cur_rdy) begin
          state_d    = ST_KSA_RUN;
          ksa_en_d   = 1'b1;
          seen_low_d = 1'b0;
        end
      end
      ST_PRGA_GO: begin
        if (cur_rdy) begin
          state_d    = ST_PRGA_RUN;
          prga_en_d  = 1'b1;
          seen_low_d = 1'b0;
        end
      end
      ST_INIT_RUN, ST_KSA_RUN, ST_PRGA_RUN: begin
        // An engine may still show rdy right after en; only a rise after a
        // low period counts as done.
        if (!cur_rdy) seen_low_d = 1'b1;
        if (seen_low_q && cur_rdy) begin
          case (state_q)
            ST_INIT_RUN: state_d = ST_KSA_GO;
            ST_KSA_RUN:  state_d = ST_PRGA_GO;
            default:     state_d = ST_IDLE;
          endcase
        end
      end
      default: state_d = ST_ERR;
    endcase

    if (!is_active(state_q)) begin
      wd_d = '0;
    end else if (state_d != state_q) begin
      wd_d = '0;
    end else if (wd_q == WD_MAX) begin
      state_d = ST_ERR;
      wd_d    = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end

    phase_d = phase_of(state_d);
    rdy_d   = (state_d == ST_IDLE);
    err_d   = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wd_q       <= '0;
      seen_low_q <= 1'b0;
      rdy_q      <= 1'b1;
      err_q      <= 1'b0;
      phase_q    <= PH_NONE;
      init_en_q  <= 1'b0;
      ksa_en_q   <= 1'b0;
      prga_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      seen_low_q <= seen_low_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
      phase_q    <= phase_d;
      init_en_q  <= init_en_d;
      ksa_en_q   <= ksa_en_d;
      prga_en_q  <= prga_en_d;
    end
  end

  assign bus.rdy     = rdy_q;
  assign bus.err     = err_q;
  assign bus.phase   = phase_q;
  assign bus.init_en = init_en_q;
  assign bus.ksa_en  = ksa_en_q;
  assign bus.prga_en = prga_en_q;

  arc4_smem_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_smem_mux (
    .phase       (phase_q),
    .init_addr   (bus.init_addr),
    .init_wrdata (bus.init_wrdata),
    .init_wren   (bus.init_wren),
    .ksa_addr    (bus.ksa_addr),
    .ksa_wrdata  (bus.ksa_wrdata),
    .ksa_wren    (bus.ksa_wren),
    .prga_addr   (bus.prga_addr),
    .prga_wrdata (bus.prga_wrdata),
    .prga_wren   (bus.prga_wren),
    .s_addr      (bus.s_addr),
    .s_wrdata    (bus.s_wrdata),
    .s_wren      (bus.s_wren)
  );

  a_en_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0({init_en_q, ksa_en_q, prga_en_q}));
  a_en_owner: assert property (@(posedge clk) disable iff (rst)
    (init_en_q -> phase_q == PH_INIT) && (ksa_en_q -> phase_q == PH_KSA) &&
    (prga_en_q -> phase_q == PH_PRGA));

endmodule

// File: doc/arc4_sched.md
Name: arc4_sched

Overview:
- Top-level sequencer for the ARC4 datapath.
- Runs the three phases that share the single 256x8 S memory (altsyncram, one port) in fixed order: S-init, then key-schedule (KSA), then keystream generation (PRGA).
- Drives each phase engine over the lab's rdy/en handshake and muxes the granted engine's memory port onto the one physical S port.
- A watchdog flags any phase that fails to complete.

Parameters:
- ADDR_W, 8, S memory address width (256 entries)
- DATA_W, 8, S memory data width
- TIMEOUT, 4096, max cycles allowed per phase before error (must be >= 2)

Ports:
- clk  in  1  system clock (CLOCK_50 at top)
- rst  in  1  synchronous, active-high reset
- en  in  1  start request from upstream, accepted only when rdy=1
- rdy  out  1  scheduler idle and able to accept en
- err  out  1  sticky watchdog error
- phase  out  2  current owner: 0 none, 1 init, 2 ksa, 3 prga
- init_en / ksa_en / prga_en  out  1 each  one-cycle start pulse to engine
- init_rdy / ksa_rdy / prga_rdy  in  1 each  engine ready
- init_addr / ksa_addr / prga_addr  in  ADDR_W each  engine S address
- init_wrdata / ksa_wrdata / prga_wrdata  in  DATA_W each  engine write data
- init_wren / ksa_wren / prga_wren  in  1 each  engine write enable
- s_addr  out  ADDR_W  to S memory
- s_wrdata  out  DATA_W  to S memory
- s_wren  out  1  to S memory

Behaviour:
- All state updates on posedge clk; rst is sampled synchronously and overrides everything.
- Reset values: state IDLE, rdy=1, err=0, phase=0, all *_en=0, s_wren=0, s_addr=0, s_wrdata=0, watchdog count=0.
- Reset mid-phase: next cycle is IDLE with phase=0 and s_wren=0. Engines are not aborted by this block; they rely on their own reset.
- States: IDLE, INIT_GO, INIT_RUN, KSA_GO, KSA_RUN, PRGA_GO, PRGA_RUN, ERR.
- IDLE:
  - rdy=1.
  - en=1 -> INIT_GO, rdy=0 from the next cycle.
  - en while rdy=0 is ignored, with no queuing.
- X_GO:
  - phase is already set to X on entry, so the mux is granted at least one cycle before X_en.
  - If X_rdy=1: assert X_en for exactly this one cycle, clear seen_low, clear watchdog, go to X_RUN.
  - If X_rdy=0: stay in X_GO. The watchdog counts here as well.
- X_RUN:
  - X_en=0.
  - Set seen_low when X_rdy=0.
  - Phase completes when seen_low=1 and X_rdy=1. An engine that holds rdy high for a cycle after en is therefore not treated as done.
  - On completion: INIT_RUN -> KSA_GO, KSA_RUN -> PRGA_GO, PRGA_RUN -> IDLE.
  - On the IDLE transition, phase=0 and rdy=1 the following cycle.
- Watchdog:
  - Counter increments each cycle in any GO/RUN state and is cleared on each state transition.
  - When the count reaches TIMEOUT-1 without a transition: -> ERR.
- ERR:
  - err=1, rdy=0, phase=0, all *_en=0.
  - Held until rst; en is ignored.
- Memory mux (combinational from registered phase):
  - phase 1/2/3 routes that engine's addr/wrdata/wren to s_*.
  - phase 0 drives s_addr=0, s_wrdata=0, s_wren=0.
  - Non-owner wren is never propagated, even when asserted.
- S read data is fanned out to all engines outside this block; it is not muxed.
- At most one *_en is high in any cycle. No *_en is high while phase differs from its engine.
- Latency:
  - en to init_en: 2 cycles minimum (IDLE->INIT_GO, then pulse in INIT_GO when init_rdy=1).
  - Engine completion to next engine's en: 2 cycles minimum.

Decomposition:
- Package arc4_pkg holds:
  - the state enum typedef (state_t)
  - the phase encoding constants PH_NONE/PH_INIT/PH_KSA/PH_PRGA
  - ADDR_W/DATA_W defaults
- One sub-module is natural: arc4_smem_mux, the combinational 3:1 port mux keyed by phase.
- Watchdog and FSM stay in arc4_sched.

Test Plan:
1. Stub engines with 256/768/10-cycle busy time. rst 1 cycle, en pulse -> init_en, ksa_en, prga_en each pulse exactly once, in order; rdy returns to 1 after the PRGA completes; err=0 throughout.
2. Memory mux. During INIT_RUN the stub writes addr=i, data=i for i=0..255; meanwhile the ksa stub asserts ksa_wren=1, addr=8'hAA. Required: s_wren follows only init. A memory model afterwards holds S[i]=i for all i; S[8'hAA]=8'hAA is unchanged by the ksa stub.
3. Slow handshake. Hold ksa_rdy=0 for 20 cycles after init completes -> scheduler stays in KSA_GO with phase=2 and ksa_en=0; ksa_en pulses on the first cycle ksa_rdy=1.
4. Lazy rdy. prga stub keeps rdy=1 for 1 cycle after en, then 0 for 5 cycles, then 1 -> completion is detected only after the low period; IDLE is not entered early.
5. Watchdog. TIMEOUT=16; ksa stub never raises rdy again after en -> err=1 and phase=0 exactly 16 cycles after entering KSA_GO's successor count window. en is then ignored until rst; after rst, err=0 and rdy=1.
6. Reset mid-KSA, plus en while busy. en pulses during INIT_RUN are ignored (init_en pulses only once). rst asserted in KSA_RUN -> next cycle state IDLE, s_wren=0, phase=0, rdy=1; a fresh en reruns the full sequence.
